param_fifo: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 4-deep, 21-bit FIFO stage between the `wrapper` result producer and downstream consumers. Data width, depth and almost-full/almost-empty thresholds are set per instance. It adds full-range occupancy, sticky overflow/underflow error flags and an optional show-ahead read mode. Everything runs on a single clock domain; in the current top level that clock is the `freq_multiplier` output clock.

---
 rtl/param_fifo_if.sv | 28 ++
 rtl/param_fifo.sv | 89 ++++++++
 tb/tb_param_fifo.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// Handshake and status bundle between param_fifo and its producer/consumer.
interface param_fifo_if #(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned ADDR_W = 2
);
  logic              wrreq;
  logic [WIDTH-1:0]  data;
  logic              rdreq;
  logic              clr_err;
  logic [WIDTH-1:0]  q;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   usedw;
  logic              overflow;
  logic              underflow;

  modport master (
    output wrreq, data, rdreq, clr_err,
    input  q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  wrreq, data, rdreq, clr_err,
    output q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy, almost flags and sticky error flags.
// Define PARAM_FIFO_SHOWAHEAD_EN for show-ahead reads (q = head word, rdreq pops).
module param_fifo #(
  parameter int unsigned WIDTH    = 21,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic         clk,
  input logic         rst,
  param_fifo_if.slave bus
);
  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_CNT   = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT   = AE_LEVEL[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   cnt;
  logic              ovf;
  logic              udf;
  logic              is_full;
  logic              is_empty;
  logic              wa;
  logic              ra;

  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);

  // A pop in the same cycle frees the slot, so a full FIFO still takes a write.
  assign ra = bus.rdreq & ~is_empty;
  assign wa = bus.wrreq & (~is_full | ra);

  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wp] <= bus.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wa) begin
        wp <= wp + 1'b1;
      end
      if (ra) begin
        rp <= rp + 1'b1;
      end
      case ({wa, ra})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ovf <= (bus.wrreq & ~wa) | (ovf & ~bus.clr_err);
      udf <= (bus.rdreq & ~ra) | (udf & ~bus.clr_err);
    end
  end

`ifdef PARAM_FIFO_SHOWAHEAD_EN
  assign bus.q = mem[rp];
`else
  logic [WIDTH-1:0] q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (ra) begin
      q_r <= mem[rp];
    end
  end

  assign bus.q = q_r;
`endif

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_CNT);
  assign bus.almost_empty = (cnt <= AE_CNT);
  assign bus.usedw        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: queue-based reference model plus directed literal checks.
module tb_param_fifo;
  localparam int unsigned WIDTH  = 21;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AF     = 3;
  localparam int unsigned AE     = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  param_fifo #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Popped-word check only meaningful for the registered-q build.
  task automatic chk_q(input string name, input logic [31:0] exp);
`ifndef PARAM_FIFO_SHOWAHEAD_EN
    chk(name, 32'(bus.q), exp);
`endif
  endtask

  // Reference model: a queue of words plus sticky flags, updated at each edge.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_q   = '0;
  logic [WIDTH-1:0] m_pop;
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;
  bit               m_ra;
  bit               m_wa;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_q   = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        m_ra = bus.rdreq && (mq.size() != 0);
        m_wa = bus.wrreq && ((mq.size() < DEPTH) || m_ra);
        if (m_ra) begin
          m_pop = mq.pop_front();
          m_q   = m_pop;
        end
        if (m_wa) mq.push_back(bus.data);
        m_ovf = (bus.wrreq && !m_wa) || (m_ovf && !bus.clr_err);
        m_udf = (bus.rdreq && !m_ra) || (m_udf && !bus.clr_err);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("m_usedw", 32'(bus.usedw), 32'(mq.size()));
        chk("m_full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("m_empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("m_afull", 32'(bus.almost_full), 32'(mq.size() >= AF));
        chk("m_aempty", 32'(bus.almost_empty), 32'(mq.size() <= AE));
        chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
        chk("m_udf", 32'(bus.underflow), 32'(m_udf));
`ifdef PARAM_FIFO_SHOWAHEAD_EN
        if (mq.size() != 0) chk("m_q", 32'(bus.q), 32'(mq[0]));
`else
        chk("m_q", 32'(bus.q), 32'(m_q));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
    bus.wrreq   = w;
    bus.rdreq   = r;
    bus.clr_err = c;
    bus.data    = d;
    @(negedge clk);
  endtask

  logic [3:0] ae_tab   = 4'b1000;
  logic [3:0] af_tab   = 4'b0011;
  logic [3:0] full_tab = 4'b0001;

  initial begin
    bus.wrreq = 1'b0; bus.rdreq = 1'b0; bus.clr_err = 1'b0; bus.data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_usedw", 32'(bus.usedw), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);
    chk_q("rst_q", 32'd0);
    rst = 1'b0;

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 21'(i + 1));
      chk("fill_usedw", 32'(bus.usedw), 32'(i + 1));
      chk("fill_aempty", 32'(bus.almost_empty), 32'(ae_tab[3 - i]));
      chk("fill_afull", 32'(bus.almost_full), 32'(af_tab[3 - i]));
      chk("fill_full", 32'(bus.full), 32'(full_tab[3 - i]));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk_q("drain_q", 32'(i + 1));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_ovf", 32'(bus.overflow), 32'd0);
    chk("drain_udf", 32'(bus.underflow), 32'd0);

    // Overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 21'(32'h10 + i));
    cyc(1'b1, 1'b0, 1'b0, 21'h1FFFF);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_usedw", 32'(bus.usedw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk_q("ovf_drain_q", 32'h10 + i);
    end
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Underflow and clear priority
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("udf_flag", 32'(bus.underflow), 32'd1);
    chk_q("udf_q_hold", 32'h13);
    cyc(1'b0, 1'b1, 1'b1, '0);
    chk("udf_set_wins", 32'(bus.underflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("udf_clr", 32'(bus.underflow), 32'd0);

    // Simultaneous read/write at full, across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 21'(32'h20 + i));
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 21'(32'h24 + k));
      chk("rw_usedw", 32'(bus.usedw), 32'd4);
      chk("rw_full", 32'(bus.full), 32'd1);
      chk_q("rw_q", 32'h20 + k);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk_q("rw_drain_q", 32'h28 + i);
    end
    cyc(1'b1, 1'b1, 1'b0, 21'h00055);
    chk("rw_empty_udf", 32'(bus.underflow), 32'd1);
    chk("rw_empty_usedw", 32'(bus.usedw), 32'd1);
    chk_q("rw_empty_q_hold", 32'h2B);
    cyc(1'b0, 1'b1, 1'b1, '0);
    chk_q("rw_empty_pop", 32'h55);
    chk("rw_empty_clr", 32'(bus.underflow), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 21'(32'h31 + i));
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("pre_rst_usedw", 32'(bus.usedw), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_usedw", 32'(bus.usedw), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("arst_afull", 32'(bus.almost_full), 32'd0);
    chk("arst_full", 32'(bus.full), 32'd0);
    chk_q("arst_q", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 21'h0ABCD);
    chk("rt_usedw", 32'(bus.usedw), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk_q("rt_q", 32'h0ABCD);
    chk("rt_empty", 32'(bus.empty), 32'd1);

`ifdef PARAM_FIFO_SHOWAHEAD_EN
    cyc(1'b1, 1'b0, 1'b0, 21'h12345);
    chk("sa_empty", 32'(bus.empty), 32'd0);
    chk("sa_q", 32'(bus.q), 32'h12345);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("sa_pop_empty", 32'(bus.empty), 32'd1);
`endif

    cyc(1'b0, 1'b0, 1'b0, '0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
